color_reg_ctrl: RTL and testbench

Controller for the 32×16 dual-port color register RAM (2 palettes × 16 entries, 12-bit RGB in bits [11:0]). It owns both RAM ports:
- **Port A:** byte-wide CPU register reads and writes, done as read-modify-write, time-shared with a palette copy engine.
- **Port B:** a fixed read-only lookup path for the pixel pipeline.

It sits between the register decoder, the pixel sequencer and the RAM instance.

---
 rtl/color_reg_ctrl.sv | 128 ++++++++++++
 tb/tb_color_reg_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_reg_ctrl.sv
// color_reg_ctrl: port-A arbiter (CPU byte read-modify-write vs palette copy) and port-B pixel lookup
// for the 32x16 color register RAM.
module color_reg_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH:0]   cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_ack,
  input  logic                  copy_start,
  input  logic                  copy_dir,
  output logic                  copy_busy,
  output logic                  copy_done,
  input  logic                  pix_valid,
  input  logic                  pix_palette,
  input  logic [3:0]            pix_index,
  output logic [11:0]           pix_rgb,
  output logic                  pix_rgb_valid,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);
  typedef enum logic [2:0] {IDLE, C_RD, C_MRG, C_WR, K_RD, K_WAIT, K_WR} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic dir, dir_n, last, last_n;
  logic ack_n, we_n, busy_n;
  logic [7:0] dout_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic unused_hi;
  assign ram_we_b = 1'b0;
  assign ram_din_b = '0;
  assign ram_addr_b = {pix_palette, pix_index};
  assign pix_rgb = pix_rgb_valid ? ram_dout_b[11:0] : 12'h000;
  assign unused_hi = ^ram_dout_b[DATA_WIDTH-1:12];
  always_comb begin
    state_n = state;
    ack_n = 1'b0;
    dout_n = cpu_dout;
    we_n = 1'b0;
    addr_n = ram_addr_a;
    din_n = ram_din_a;
    busy_n = copy_busy;
    cnt_n = cnt;
    dir_n = dir;
    last_n = 1'b0;
    case (state)
      IDLE: begin
        // a held request is not re-served in its own ack cycle
        if (cpu_req && !cpu_ack) begin
          state_n = C_RD;
          addr_n = cpu_addr[ADDR_WIDTH:1];
        end else if (copy_busy) begin
          state_n = K_RD;
          addr_n = {dir, cnt};
        end
      end
      C_RD: state_n = C_MRG;
      C_MRG: begin
        ack_n = 1'b1;
        dout_n = cpu_addr[0] ? ram_dout_a[15:8] : ram_dout_a[7:0];
        we_n = cpu_we;
        din_n = cpu_addr[0] ? {cpu_din, ram_dout_a[7:0]} : {ram_dout_a[15:8], cpu_din};
        state_n = cpu_we ? C_WR : IDLE;
      end
      C_WR: state_n = IDLE;
      K_RD: state_n = K_WAIT;
      K_WAIT: begin
        we_n = 1'b1;
        addr_n = {~dir, cnt};
        din_n = ram_dout_a;
        state_n = K_WR;
      end
      K_WR: begin
        cnt_n = cnt + 4'd1;
        busy_n = (cnt != 4'hF);
        last_n = (cnt == 4'hF);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (copy_start && !copy_busy) begin
      busy_n = 1'b1;
      cnt_n = 4'd0;
      dir_n = copy_dir;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cpu_ack <= 1'b0;
      cpu_dout <= '0;
      ram_we_a <= 1'b0;
      ram_addr_a <= '0;
      ram_din_a <= '0;
      copy_busy <= 1'b0;
      copy_done <= 1'b0;
      pix_rgb_valid <= 1'b0;
      cnt <= '0;
      dir <= 1'b0;
      last <= 1'b0;
    end else begin
      state <= state_n;
      cpu_ack <= ack_n;
      cpu_dout <= dout_n;
      ram_we_a <= we_n;
      ram_addr_a <= addr_n;
      ram_din_a <= din_n;
      copy_busy <= busy_n;
      copy_done <= last;
      pix_rgb_valid <= pix_valid;
      cnt <= cnt_n;
      dir <= dir_n;
      last <= last_n;
    end
  end
endmodule

// File: tb/tb_color_reg_ctrl.sv
// tb_color_reg_ctrl: vector tables and scoreboards for color_reg_ctrl, driving a behavioural
// dual-port RAM with registered read ports.
module tb_color_reg_ctrl;
  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } cpu_vec_t;
  typedef struct {
    logic [4:0]  ent;
    logic [11:0] exp;
  } pix_vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req, cpu_we, cpu_ack;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_din, cpu_dout;
  logic copy_start, copy_dir, copy_busy, copy_done;
  logic pix_valid, pix_palette, pix_rgb_valid;
  logic [3:0] pix_index;
  logic [11:0] pix_rgb;
  logic ram_we_a, ram_we_b;
  logic [4:0] ram_addr_a, ram_addr_b;
  logic [15:0] ram_din_a, ram_dout_a, ram_din_b, ram_dout_b;
  logic pl_we;
  logic [4:0] pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [32];
  int tests = 0;
  int fails = 0;
  logic [7:0] cpu_q[$];
  logic [11:0] pix_q[$];
  logic pix_mon = 1'b0;
  logic [7:0] ce;
  logic [11:0] pe;

  color_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .copy_start(copy_start), .copy_dir(copy_dir), .copy_busy(copy_busy), .copy_done(copy_done),
    .pix_valid(pix_valid), .pix_palette(pix_palette), .pix_index(pix_index),
    .pix_rgb(pix_rgb), .pix_rgb_valid(pix_rgb_valid),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (pl_we) mem[pl_addr] <= pl_data;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cpu_ack_unexpected: dout %0h, expected no ack", cpu_dout);
      end else begin
        ce = cpu_q.pop_front();
        chk("cpu_dout", 32'(cpu_dout), 32'(ce));
      end
    end
  end

  always @(negedge clk) begin
    if (pix_mon) begin
      if (pix_rgb_valid) begin
        if (pix_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pix_unexpected: rgb %0h, expected no valid", pix_rgb);
        end else begin
          pe = pix_q.pop_front();
          chk("pix_rgb", 32'(pix_rgb), 32'(pe));
        end
      end else chk("pix_rgb_gated", 32'(pix_rgb), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'(i < 16 ? i * 'h111 : 'hC000 | (i * 3));
  endfunction

  task automatic load(input int a, input logic [15:0] v);
    pl_we = 1'b1;
    pl_addr = 5'(a);
    pl_data = v;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [5:0] a, input logic [7:0] d,
                            input logic [7:0] exp, input int exp_lat);
    int n;
    cpu_q.push_back(exp);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_din = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 40);
    chk("cpu_ack_seen", 32'(cpu_ack), 1);
    if (!cpu_ack) cpu_q.delete();
    chk("cpu_latency", 32'(n), 32'(exp_lat));
    cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_ack_width", 32'(cpu_ack), 0);
  endtask

  task automatic copy_watch(input int limit, input int exp_n, input int repulse_n);
    int first = 0;
    int pulses = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) copy_start = 1'b0;
      if (repulse_n != 0 && n == repulse_n) begin
        copy_start = 1'b1;
        copy_dir = ~copy_dir;
      end
      if (repulse_n != 0 && n == repulse_n + 1) begin
        copy_start = 1'b0;
        copy_dir = ~copy_dir;
      end
      if (copy_done) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    chk("copy_done_time", 32'(first), 32'(exp_n));
    chk("copy_done_pulses", 32'(pulses), 1);
    chk("copy_busy_end", 32'(copy_busy), 0);
  endtask

  task automatic verify_copy();
    for (int i = 0; i < 16; i++) begin
      chk("copy_dst", 32'(mem[16+i]), 32'(i * 'h111));
      chk("copy_src", 32'(mem[i]), 32'(i * 'h111));
    end
  endtask

  task automatic reset_outputs();
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);
    chk("rst_we_a", 32'(ram_we_a), 0);
    chk("rst_addr_a", 32'(ram_addr_a), 0);
    chk("rst_din_a", 32'(ram_din_a), 0);
    chk("rst_copy_busy", 32'(copy_busy), 0);
    chk("rst_copy_done", 32'(copy_done), 0);
    chk("rst_pix_valid", 32'(pix_rgb_valid), 0);
    chk("rst_pix_rgb", 32'(pix_rgb), 0);
  endtask

  initial begin
    cpu_vec_t cv[9];
    pix_vec_t pv[32];
    int k;
    cv[0] = '{1'b1, 6'h0B, 8'h0F, 8'h0A};
    cv[1] = '{1'b0, 6'h0A, 8'h00, 8'hBC};
    cv[2] = '{1'b0, 6'h0B, 8'h00, 8'h0F};
    cv[3] = '{1'b1, 6'h00, 8'h5A, 8'h00};
    cv[4] = '{1'b0, 6'h00, 8'h00, 8'h5A};
    cv[5] = '{1'b0, 6'h01, 8'h00, 8'h00};
    cv[6] = '{1'b1, 6'h3F, 8'h81, 8'hC0};
    cv[7] = '{1'b0, 6'h3F, 8'h00, 8'h81};
    cv[8] = '{1'b0, 6'h3E, 8'h00, 8'h5D};
    for (int i = 0; i < 32; i++) pv[i] = '{5'((i * 7) % 32), 12'(((i * 7) % 16) * 'h111)};
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    copy_start = 1'b0; copy_dir = 1'b0;
    pix_valid = 1'b0; pix_palette = 1'b0; pix_index = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("we_b_tied", 32'(ram_we_b), 0);
    chk("din_b_tied", 32'(ram_din_b), 0);
    pix_palette = 1'b1;
    pix_index = 4'hA;
    #1;
    chk("addr_b_comb", 32'(ram_addr_b), 32'h1A);
    @(negedge clk);
    // byte read-modify-write table
    for (int i = 0; i < 32; i++) load(i, init_val(i));
    load(5, 16'h0ABC);
    for (int i = 0; i < 9; i++) cpu_access(cv[i].we, cv[i].addr, cv[i].din, cv[i].exp, 3);
    chk("rmw_entry5", 32'(mem[5]), 32'h0FBC);
    chk("rmw_entry0", 32'(mem[0]), 32'h005A);
    chk("rmw_entry31", 32'(mem[31]), 32'h815D);
    // uncontended copy 0 -> 1
    for (int i = 0; i < 32; i++) load(i, init_val(i));
    copy_start = 1'b1;
    copy_dir = 1'b0;
    copy_watch(80, 66, 0);
    verify_copy();
    // CPU read of entry 20 held across entry 4 of a copy
    for (int i = 16; i < 32; i++) load(i, init_val(i));
    copy_start = 1'b1;
    copy_dir = 1'b0;
    fork
      copy_watch(90, 69, 0);
      begin
        repeat (18) @(negedge clk);
        cpu_access(1'b0, 6'h28, 8'h00, 8'h44, 6);
      end
    join
    verify_copy();
    // copy_start and cpu_req together, plus an ignored second copy_start
    for (int i = 16; i < 32; i++) load(i, init_val(i));
    copy_start = 1'b1;
    copy_dir = 1'b0;
    fork
      copy_watch(100, 68, 10);
      cpu_access(1'b0, 6'h06, 8'h00, 8'h33, 3);
    join
    verify_copy();
    // pixel stream during a 1 -> 0 copy of identical palettes
    pix_mon = 1'b1;
    copy_start = 1'b1;
    copy_dir = 1'b1;
    fork
      copy_watch(80, 66, 0);
      begin
        for (int i = 0; i < 32; i++) begin
          pix_valid = 1'b1;
          {pix_palette, pix_index} = pv[i].ent;
          pix_q.push_back(pv[i].exp);
          @(negedge clk);
        end
        pix_valid = 1'b0;
        {pix_palette, pix_index} = 5'h1F;
        repeat (4) @(negedge clk);
      end
    join
    chk("pix_queue_drained", 32'(pix_q.size()), 0);
    pix_mon = 1'b0;
    verify_copy();
    // asynchronous reset while entry 7 write is on port A
    for (int i = 16; i < 32; i++) load(i, init_val(i));
    copy_start = 1'b1;
    copy_dir = 1'b0;
    pix_valid = 1'b1;
    pix_palette = 1'b0;
    pix_index = 4'h1;
    repeat (32) begin
      @(negedge clk);
      copy_start = 1'b0;
    end
    chk("pre_rst_we_a", 32'(ram_we_a), 1);
    chk("pre_rst_busy", 32'(copy_busy), 1);
    chk("pre_rst_pix_valid", 32'(pix_rgb_valid), 1);
    rst_n = 1'b0;
    #1;
    reset_outputs();
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (ram_we_a || copy_busy) k++;
    end
    chk("post_rst_idle", 32'(k), 0);
    chk("rst_entry22_copied", 32'(mem[22]), 32'h0666);
    chk("rst_entry23_untouched", 32'(mem[23]), 32'(init_val(23)));
    chk("cpu_queue_drained", 32'(cpu_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
